hamming_encoder_stream: RTL and testbench
=========================================

// Module: hamming_encoder_stream
// PURPOSE
//  Parametrised, streaming Hamming encoder: generalises the fixed (7,4) encoder to any DATA_W.
//  Has valid/ready handshakes on both sides, an output FIFO that absorbs downstream stalls,
//  a sync flush and a codeword counter. Sits between the byte/nibble source and the UART TX serialiser.
// PARAMETERS
//  DATA_W      4   data bits per word, 1..57.
//                  P = min p with 2^p >= DATA_W+p+1; HAM_W = DATA_W+P.
//  FIFO_DEPTH  2   output FIFO entries; power of 2, >=2.
//  CNT_W       16  width of the delivered-codeword counter.
//  CODE_W is derived: HAM_W, or HAM_W+1 with HAMMING_SECDED_EN.
// PORTS
//  clk        in   1       clock, rising edge.
//  rst_n      in   1       async active-low reset.
//  ena        in   1       global enable; gates input acceptance only.
//  clr        in   1       sync flush: empties FIFO, zeroes counter.
//  in_valid   in   1       in_data valid.
//  in_ready   out  1       block accepts in_data this cycle.
//  in_data    in   DATA_W  data word.
//  out_valid  out  1       out_code valid (FIFO non-empty).
//  out_ready  in   1       downstream accepts out_code.
//  out_code   out  CODE_W  codeword at FIFO head.
//  code_cnt   out  CNT_W   codewords delivered (out handshakes), wraps.
// BEHAVIOUR
//  - Reset (async, rst_n=0): FIFO empty; out_valid=0, out_code=0, code_cnt=0.
//    in_ready=0 while rst_n=0. Any word in flight is discarded.
//  - in_ready  = ena & !full & !clr (combinational).
//  - out_valid = !empty. out_code = FIFO head entry, stored registered.
//  - Push on in_valid&in_ready. The word is encoded combinationally and written at that edge.
//    Latency: accepted at edge N -> out_valid=1 after edge N if FIFO was empty.
//  - Pop on out_valid&out_ready. code_cnt increments on each pop, mod 2^CNT_W.
//  - Simultaneous push+pop: allowed when not full. Occupancy is unchanged; order is preserved.
//  - Full: in_ready=0; a pop that cycle frees a slot, so in_ready=1 next cycle (no same-cycle pass-through).
//  - Empty: out_valid=0; out_code holds its last value (0 after reset/clr).
//  - Occupancy counter 0..FIFO_DEPTH. Pointers wrap mod FIFO_DEPTH.
//  - clr=1: at the next edge the FIFO empties and code_cnt=0. clr overrides push and pop.
//    Pops presented while clr=1 are not counted.
//  - ena=0: no new input; the FIFO keeps draining downstream.
//  - Encoding, Hamming positions 1..HAM_W:
//    * Parity p_k sits at position 2^(k-1), k=1..P.
//    * Data bits d0,d1,... fill non-power-of-2 positions in ascending order.
//    * p_k = XOR of data bits at positions with bit (k-1) set.
//    * Position i maps to out_code[HAM_W-i]: position 1 is the MSB of the Hamming field.
//    * DATA_W=4 gives {p1,p2,d0,p3,d1,d2,d3}.
//  - in_data is sampled only on handshake; X on in_data when in_valid=0 never propagates.
// CONFIGURATION
//  HAMMING_SECDED_EN defined:
//   - CODE_W=HAM_W+1; out_code[CODE_W-1] = XOR of out_code[HAM_W-1:0] (even overall parity).
//   - Hamming field in out_code[HAM_W-1:0]. Enables double-error detection at the decoder.
//  HAMMING_SECDED_EN undefined:
//   - CODE_W=HAM_W; out_code is the plain Hamming code.
// TESTING
//  1. DATA_W=4, in_data=4'b1011, out_ready=1 -> next cycle out_valid=1, out_code=7'h55, code_cnt=1.
//  2. DATA_W=4 with HAMMING_SECDED_EN, in_data=4'b0001 -> out_code=8'hF0.
//     Without the macro -> 7'h70.
//  3. out_ready=0, stream 3 words, FIFO_DEPTH=2 -> in_ready=0 after 2nd accept.
//     Raise out_ready -> 3 words out in order, no loss/duplication, code_cnt=3.
//  4. Full FIFO, clr=1 one cycle with out_ready=1 -> out_valid=0, code_cnt=0, in_ready=1 next cycle.
//  5. DATA_W=11 (HAM_W=15), all 2048 inputs -> each codeword's syndrome=0.
//     Every single-bit flip gives syndrome = flipped position.
//  6. Assert rst_n=0 mid-stream with 2 words queued and ena=0 -> outputs 0 immediately.
//     After release: out_valid=0, no stale words emitted.

Source files
------------

// File: rtl/hamming_encoder_stream.sv
// -----------------------------------------------------------------------------
// hamming_encoder_stream
//
// Streaming, parametrised Hamming encoder. Each accepted data word is encoded
// combinationally and written into a small output FIFO, which soaks up stalls
// from the downstream serialiser. Also provides a synchronous flush and a
// counter of delivered codewords.
//
// Optional feature macro: HAMMING_SECDED_EN
//   When defined, an even overall-parity bit is prepended as the MSB of
//   out_code, so the decoder can perform SECDED.
//   When undefined, out_code is the plain Hamming code.
//
// Parameters
//   DATA_W      data bits per word (1..57)
//   FIFO_DEPTH  output FIFO entries (power of 2, >= 2)
//   CNT_W       width of the delivered-codeword counter
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   ena        in   global enable, gates input acceptance only
//   clr        in   synchronous flush: empties FIFO, zeroes counter
//   in_valid   in   in_data is valid
//   in_ready   out  block accepts in_data this cycle
//   in_data    in   data word
//   out_valid  out  FIFO non-empty, out_code valid
//   out_ready  in   downstream accepts out_code
//   out_code   out  codeword at FIFO head (registered)
//   code_cnt   out  number of delivered codewords, wraps
// -----------------------------------------------------------------------------
module hamming_encoder_stream #(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16,
    // Smallest p with 2^p >= DATA_W + p + 1
    localparam int PAR_W = (DATA_W + 2 <= 4)  ? 2 :
                           (DATA_W + 3 <= 8)  ? 3 :
                           (DATA_W + 4 <= 16) ? 4 :
                           (DATA_W + 5 <= 32) ? 5 :
                           (DATA_W + 6 <= 64) ? 6 : 7,
    localparam int HAM_W = DATA_W + PAR_W,
`ifdef HAMMING_SECDED_EN
    localparam int CODE_W = HAM_W + 1
`else
    localparam int CODE_W = HAM_W
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [CNT_W-1:0]  code_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    // Hamming positions are numbered 1..HAM_W; position 1 lands on the MSB of
    // the field. Parity bits occupy the power-of-2 positions, data fills the
    // rest in ascending order. Parity positions are still zero when each
    // parity bit is computed, and no other parity position shares its
    // selecting bit, so XORing every position with bit k set is exact.
    function automatic logic [HAM_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
        logic [HAM_W:1]   pos_bits;
        logic [HAM_W-1:0] code;
        logic             par;
        int               d_idx;
        pos_bits = '0;
        code     = '0;
        d_idx    = 0;
        for (int pos = 1; pos <= HAM_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                pos_bits[pos] = d[d_idx];
                d_idx++;
            end
        end
        for (int k = 0; k < PAR_W; k++) begin
            par = 1'b0;
            for (int pos = 1; pos <= HAM_W; pos++) begin
                if (pos[k]) par = par ^ pos_bits[pos];
            end
            pos_bits[1 << k] = par;
        end
        for (int pos = 1; pos <= HAM_W; pos++) begin
            code[HAM_W - pos] = pos_bits[pos];
        end
        return code;
    endfunction

    logic [CODE_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  occ_nxt;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [HAM_W-1:0]  ham_field;
    logic [CODE_W-1:0] enc_code;

    assign ham_field = hamming_encode(in_data);

`ifdef HAMMING_SECDED_EN
    assign enc_code = {^ham_field, ham_field};
`else
    assign enc_code = ham_field;
`endif

    assign full      = (occ == OCC_FULL);
    assign empty     = (occ == '0);
    // rst_n is folded in so in_ready reads low throughout reset.
    assign in_ready  = rst_n & ena & ~full & ~clr;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    // A flush overrides any pop, so a pop under clr is neither taken nor counted.
    assign pop       = out_valid & out_ready & ~clr;

    always_comb begin
        occ_nxt    = occ;
        rd_ptr_nxt = rd_ptr;
        if (push && !pop) begin
            occ_nxt = occ + 1'b1;
        end else if (pop && !push) begin
            occ_nxt = occ - 1'b1;
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc_code;
        end
    end

    // out_code is a register holding the next head. When the next head is the
    // slot being written this cycle (FIFO empty, or one entry that is popped
    // while pushing) it is taken straight from the encoder. An empty FIFO
    // leaves out_code holding its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            out_code <= '0;
            code_cnt <= '0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            out_code <= '0;
            code_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_nxt;
            occ    <= occ_nxt;
            if (pop) begin
                code_cnt <= code_cnt + 1'b1;
            end
            if (occ_nxt != '0) begin
                if (push && (rd_ptr_nxt == wr_ptr)) begin
                    out_code <= enc_code;
                end else begin
                    out_code <= mem[rd_ptr_nxt];
                end
            end
        end
    end

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// -----------------------------------------------------------------------------
// tb_hamming_encoder_stream
//
// Scoreboard bench for hamming_encoder_stream. Stimulus pushes the
// hand-computed codeword for each accepted word into a queue; a negedge
// monitor pops and compares on every output handshake and tracks the
// delivered-codeword count. A second instance with DATA_W=11 is swept over
// all inputs to check syndrome, single-bit-flip and data-recovery properties.
// -----------------------------------------------------------------------------
module tb_hamming_encoder_stream;

    localparam int DATA_W     = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 16;
`ifdef HAMMING_SECDED_EN
    localparam int CODE_W   = 8;
    localparam int CODE_W11 = 16;
`else
    localparam int CODE_W   = 7;
    localparam int CODE_W11 = 15;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic [CNT_W-1:0]  code_cnt;

    logic                ena_b;
    logic                clr_b;
    logic                in_valid_b;
    logic                in_ready_b;
    logic [10:0]         in_data_b;
    logic                out_valid_b;
    logic                out_ready_b;
    logic [CODE_W11-1:0] out_code_b;
    logic [CNT_W-1:0]    code_cnt_b;

    int checks = 0;
    int errors = 0;

    logic [CODE_W-1:0] exp_q[$];
    logic [CODE_W-1:0] exp_head;
    int                model_cnt = 0;

    always #5 clk = ~clk;

    hamming_encoder_stream #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .code_cnt(code_cnt)
    );

    hamming_encoder_stream #(
        .DATA_W(11), .FIFO_DEPTH(2), .CNT_W(CNT_W)
    ) u_dut11 (
        .clk(clk), .rst_n(rst_n), .ena(ena_b), .clr(clr_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_code(out_code_b),
        .code_cnt(code_cnt_b)
    );

    function automatic logic [CODE_W-1:0] withSecded(input logic [6:0] h);
`ifdef HAMMING_SECDED_EN
        return {^h, h};
`else
        return h;
`endif
    endfunction

    // Syndrome of a 15-bit Hamming field: XOR of the positions holding a 1.
    function automatic int syndrome15(input logic [14:0] c);
        int s;
        s = 0;
        for (int i = 1; i <= 15; i++) begin
            if (c[15 - i]) s = s ^ i;
        end
        return s;
    endfunction

    function automatic logic [10:0] extract11(input logic [14:0] c);
        logic [10:0] d;
        int          j;
        d = '0;
        j = 0;
        for (int i = 1; i <= 15; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j] = c[15 - i];
                j++;
            end
        end
        return d;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted; the expected codeword is
    // queued at the handshake. Returns 1 ns after the accepting edge.
    task automatic applyStimulus(input logic [3:0] d, input logic [6:0] h);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        if (done) begin
            exp_q.push_back(withSecded(h));
            @(posedge clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: data 0x%0h not accepted in 50 cycles", d);
            in_valid = 1'b0;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Monitor: compares every output handshake against the scoreboard and
    // keeps a model of code_cnt (reset and flush clear it).
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            checkOutput("code_cnt_track", code_cnt, model_cnt[CNT_W-1:0]);
            if (clr) begin
                exp_q.delete();
                model_cnt = 0;
            end else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got 0x%0h, expected no word", out_code);
                end else begin
                    exp_head = exp_q.pop_front();
                    checkOutput("out_code", out_code, exp_head);
                end
                model_cnt++;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          flips_ok;
        logic [14:0] field;
        logic [14:0] flipped;

        rst_n = 1'b0; ena = 1'b1; clr = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        ena_b = 1'b1; clr_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;

        #3;
        $display("[TB] reset state");
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_code", out_code, 0);
        checkOutput("rst_code_cnt", code_cnt, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        $display("[TB] single word 1011");
        out_ready = 1'b1;
        applyStimulus(4'b1011, 7'h55);
        idle();
        @(negedge clk);
        checkOutput("t1_out_valid", out_valid, 1);
        checkOutput("t1_out_code", out_code, withSecded(7'h55));
        tick(1);
        @(negedge clk);
        checkOutput("t1_empty_valid", out_valid, 0);
        checkOutput("t1_code_cnt", code_cnt, 1);
        checkOutput("t1_hold_code", out_code, withSecded(7'h55));
        tick(1);

        $display("[TB] single word 0001");
        applyStimulus(4'b0001, 7'h70);
        idle();
        @(negedge clk);
        checkOutput("t2_out_code", out_code, withSecded(7'h70));
        tick(1);

        $display("[TB] flush then backpressure");
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        @(negedge clk);
        checkOutput("t3_clr_cnt", code_cnt, 0);
        checkOutput("t3_clr_code", out_code, 0);
        tick(1);
        out_ready = 1'b0;
        applyStimulus(4'b0010, 7'h4C);
        applyStimulus(4'b0100, 7'h2A);
        idle();
        @(negedge clk);
        checkOutput("t3_full_in_ready", in_ready, 0);
        checkOutput("t3_full_valid", out_valid, 1);
        checkOutput("t3_head_code", out_code, withSecded(7'h4C));
        tick(1);
        out_ready = 1'b1;
        applyStimulus(4'b1000, 7'h69);
        idle();
        tick(4);
        @(negedge clk);
        checkOutput("t3_code_cnt", code_cnt, 3);
        checkOutput("t3_drained", exp_q.size(), 0);
        tick(1);

        $display("[TB] back-to-back streaming");
        applyStimulus(4'b0110, 7'h66);
        applyStimulus(4'b1100, 7'h43);
        applyStimulus(4'b0101, 7'h5A);
        applyStimulus(4'b1010, 7'h25);
        idle();
        tick(3);
        @(negedge clk);
        checkOutput("t4_code_cnt", code_cnt, 7);
        checkOutput("t4_drained", exp_q.size(), 0);
        tick(1);

        $display("[TB] flush of a full FIFO");
        out_ready = 1'b0;
        applyStimulus(4'b0111, 7'h16);
        applyStimulus(4'b1111, 7'h7F);
        idle();
        @(negedge clk);
        checkOutput("t5_full_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        clr = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("t5_clr_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        checkOutput("t5_out_valid", out_valid, 0);
        checkOutput("t5_code_cnt", code_cnt, 0);
        checkOutput("t5_out_code", out_code, 0);
        checkOutput("t5_in_ready", in_ready, 1);
        tick(1);

        $display("[TB] reset mid-stream");
        applyStimulus(4'b1100, 7'h43);
        idle();
        tick(2);
        out_ready = 1'b0;
        applyStimulus(4'b1011, 7'h55);
        applyStimulus(4'b0101, 7'h5A);
        idle();
        ena = 1'b0;
        @(negedge clk);
        checkOutput("t6_pre_valid", out_valid, 1);
        checkOutput("t6_pre_cnt", code_cnt, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", out_valid, 0);
        checkOutput("t6_rst_code", out_code, 0);
        checkOutput("t6_rst_cnt", code_cnt, 0);
        checkOutput("t6_rst_in_ready", in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(3);
        @(negedge clk);
        checkOutput("t6_post_valid", out_valid, 0);
        checkOutput("t6_post_cnt", code_cnt, 0);
        tick(1);
        ena = 1'b1;
        applyStimulus(4'b0100, 7'h2A);
        idle();
        tick(2);
        @(negedge clk);
        checkOutput("t6_resume_cnt", code_cnt, 1);
        tick(1);

        $display("[TB] DATA_W=11 sweep");
        @(negedge clk);
        checkOutput("b_in_ready", in_ready_b, 1);
        for (int v = 0; v < 2048; v++) begin
            @(posedge clk);
            #1;
            in_valid_b = 1'b1;
            in_data_b  = v[10:0];
            @(posedge clk);
            #1;
            in_valid_b = 1'b0;
            @(negedge clk);
            field = out_code_b[14:0];
            checkOutput("b_out_valid", out_valid_b, 1);
            checkOutput("b_syndrome", syndrome15(field), 0);
            checkOutput("b_data", extract11(field), v[10:0]);
`ifdef HAMMING_SECDED_EN
            checkOutput("b_overall_parity", ^out_code_b, 0);
`endif
            flips_ok = 1'b1;
            for (int i = 1; i <= 15; i++) begin
                flipped = field ^ (15'd1 << (15 - i));
                if (syndrome15(flipped) != i) flips_ok = 1'b0;
            end
            checkOutput("b_flip_syndrome", flips_ok, 1);
        end
        tick(2);
        @(negedge clk);
        checkOutput("b_code_cnt", code_cnt_b, 2048);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
